bayer_gray_downsampler: RTL and testbench
=========================================

# bayer_gray_downsampler

Converts the raw 12-bit Bayer stream from the D5M capture stage into a 640x480 grayscale stream for the Sobel edge pipeline. Each 2x2 Bayer quad (R, G1, G2, B) from the 1280x960 sensor window becomes one gray pixel, the truncated mean of the four samples. Output pixels carry halved coordinates. The block runs in the pixel-clock domain, between CCD_Capture and image_processing_pipeline.

## Interface
- IN_WIDTH, 1280: raw pixels per sensor row; line-buffer depth.
- DATA_W, 12: sample width in and out.
- iCLK  in  1: pixel clock; all logic on posedge.
- iRST  in  1: synchronous, active-high reset.
- iDATA  in  DATA_W: raw Bayer sample.
- iDVAL  in  1: iDATA/iX_Cont/iY_Cont valid this cycle.
- iX_Cont  in  16: raw column, 0..IN_WIDTH-1.
- iY_Cont  in  16: raw row.
- oDATA  out  DATA_W: gray value.
- oDVAL  out  1: one-cycle strobe per output pixel.
- oX_Cont  out  16: output column (iX_Cont>>1).
- oY_Cont  out  16: output row (iY_Cont>>1).
- oSOF  out  1: high with oDVAL for the output pixel at (0,0).
- oDROP  out  1: one-cycle pulse when an odd/odd pixel cannot form a quad.

## Operation
- Accept an input beat only when iDVAL=1 and iX_Cont<IN_WIDTH. Other beats are ignored and change no state.
- Even row (iY_Cont[0]=0):
  - Write iDATA to line_buf[iX_Cont].
  - Set row_tag=iY_Cont and row_valid=1.
  - No output.
- Odd row, even column:
  - Latch cur_prev=iDATA and set have_prev=1.
  - Read line_buf[iX_Cont] and hold it as up_prev.
- Odd row, odd column:
  - Read line_buf[iX_Cont] as up_cur.
  - The quad is complete when have_prev=1, row_valid=1 and row_tag==iY_Cont-1. Then emit the output and clear have_prev.
  - If any of those conditions fails, pulse oDROP instead of oDVAL and clear have_prev.
- Arithmetic:
  - sum = up_prev + up_cur + cur_prev + iDATA, computed at DATA_W+2 bits with no overflow.
  - oDATA = sum[DATA_W+1:2]. This is truncation, not rounding. Maximum result is 4095.
- oX_Cont and oY_Cont are the accepted coordinates right-shifted by 1, pipelined alongside the data.
- oSOF = oDVAL and output coordinate (0,0).
- line_buf is a single-port-write, synchronous-read RAM of IN_WIDTH x DATA_W. Its contents are not cleared by reset.

## Timing
- Latency: oDVAL rises exactly 2 cycles after the iCLK edge that accepts the completing odd/odd pixel. oDROP has the same 2-cycle latency.
- Throughput: one input beat per cycle. At most one output per two accepted beats.
- Gaps in iDVAL stall nothing. up_prev and cur_prev hold across gaps.
- Reset values:
  - oDATA=0, oDVAL=0, oX_Cont=0, oY_Cont=0, oSOF=0, oDROP=0.
  - have_prev=0, row_valid=0, row_tag=0.
  - Pipeline valid bits are cleared, so nothing already in flight emerges after reset.
- Reset mid-frame: no oDVAL until a new even row has been written and its following odd row arrives. A first odd/odd pixel after reset gives oDROP.
- Row sequence break (e.g. a skipped even row): odd/odd pixels give oDROP until row_tag matches again.
- New even row overwrites line_buf in place. Reads in an odd row always see the latest even row.
- Odd-column pixel without a preceding even-column pixel in the same odd row gives oDROP (have_prev=0).
- Even-column pixel arriving while have_prev=1 overwrites cur_prev and up_prev; no output results.
- Output runs no faster than 1 pixel per 2 cycles. No backpressure exists; the downstream stage must accept every oDVAL.

## Test plan
- Reset: assert iRST 3 cycles with iDVAL toggling. Required: every output is 0 throughout, and for 2 cycles after release.
- Flat field: rows 0 and 1, all samples 100, contiguous iDVAL, X 0..1279. Required:
  - 640 oDVAL strobes, oDATA=100, oX_Cont 0..639, oY_Cont=0.
  - oSOF only on the first strobe.
  - Each strobe 2 cycles after its odd-column input.
- Arithmetic: quad (4095,4095,4095,4095) -> oDATA=4095. Quad (1,2,3,5) -> oDATA=2. Quad (0,0,0,3) -> oDATA=0.
- Gapped input: repeat the flat-field rows with iDVAL low every other cycle. Required: identical oDATA/oX_Cont sequence and 640 strobes.
- Missing upper row: after reset, drive row 1 only. Required: 640 oDROP pulses and no oDVAL. Then rows 2 and 3 -> 640 valid outputs with oY_Cont=1.
- Out-of-range and mid-row reset:
  - iX_Cont=1280 beats produce no state change and no output.
  - iRST at X=600 of row 1 clears everything; the next odd row without a new even row gives only oDROP.

Source files
------------

// File: rtl/bayer_gray_downsampler.sv
// Bayer-to-gray 2x2 downsampler: each R/G1/G2/B quad from the raw sensor
// window becomes one gray pixel equal to the truncated mean of its four
// samples. Even rows are parked in a line buffer. Odd rows pair each
// even/odd column couple with the buffered row above it.
// Output appears 2 cycles after the beat that completes a quad.
module bayer_gray_downsampler #(
  parameter int IN_WIDTH = 1280,
  parameter int DATA_W   = 12
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iDVAL,
  input  logic [15:0]       iX_Cont,
  input  logic [15:0]       iY_Cont,
  output logic [DATA_W-1:0] oDATA,
  output logic              oDVAL,
  output logic [15:0]       oX_Cont,
  output logic [15:0]       oY_Cont,
  output logic              oSOF,
  output logic              oDROP
);

  localparam int          AW       = $clog2(IN_WIDTH);
  localparam int          SW       = DATA_W + 2;
  localparam logic [15:0] WIDTH_16 = 16'(IN_WIDTH);

  // Input qualification and decode
  logic          accept;
  logic          odd_row;
  logic          odd_col;
  logic [AW-1:0] addr;
  logic          buf_we;
  logic          buf_re;

  assign accept  = iDVAL && (iX_Cont < WIDTH_16);
  assign odd_row = iY_Cont[0];
  assign odd_col = iX_Cont[0];
  assign addr    = iX_Cont[AW-1:0];
  assign buf_we  = accept && !odd_row && !iRST;
  assign buf_re  = accept && odd_row;

  // Line buffer holding the most recent even row; not cleared by reset
  logic [DATA_W-1:0] line_buf [IN_WIDTH];
  logic [DATA_W-1:0] line_rd;

  // Synchronous-read, single-write RAM for the upper row of each quad
  always_ff @(posedge iCLK) begin
    if (buf_we) begin
      line_buf[addr] <= iDATA;
    end
    if (buf_re) begin
      line_rd <= line_buf[addr];
    end
  end

  // Row/quad tracking state
  logic              row_valid_q, row_valid_d;
  logic [15:0]       row_tag_q, row_tag_d;
  logic              have_prev_q, have_prev_d;
  logic [DATA_W-1:0] cur_prev_q, cur_prev_d;
  logic [DATA_W-1:0] up_prev_q, up_prev_d;

  // Stage 1: odd-row beat waiting for its line-buffer read
  logic              s1_valid_q, s1_valid_d;
  logic              s1_odd_col_q, s1_odd_col_d;
  logic              s1_ok_q, s1_ok_d;
  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic [DATA_W-1:0] s1_prev_q, s1_prev_d;
  logic [15:0]       s1_x_q, s1_x_d;
  logic [15:0]       s1_y_q, s1_y_d;

  // Stage 2: quad sum or drop decision
  logic              s2_valid_q, s2_valid_d;
  logic              s2_drop_q, s2_drop_d;
  logic [SW-1:0]     s2_sum_q, s2_sum_d;
  logic [15:0]       s2_x_q, s2_x_d;
  logic [15:0]       s2_y_q, s2_y_d;

  // Output registers
  logic [DATA_W-1:0] odata_q, odata_d;
  logic              odval_q, odval_d;
  logic [15:0]       ox_q, ox_d;
  logic [15:0]       oy_q, oy_d;
  logic              osof_q, osof_d;
  logic              odrop_q, odrop_d;

  logic quad_ok;

  // A quad closes only if its left half was seen in this row and the
  // buffered even row is the one directly above.
  assign quad_ok = have_prev_q && row_valid_q && (row_tag_q == (iY_Cont - 16'd1));

  // Next-state for tracking state and all pipeline stages
  always_comb begin
    row_valid_d  = row_valid_q;
    row_tag_d    = row_tag_q;
    have_prev_d  = have_prev_q;
    cur_prev_d   = cur_prev_q;
    up_prev_d    = up_prev_q;
    s1_valid_d   = 1'b0;
    s1_odd_col_d = s1_odd_col_q;
    s1_ok_d      = s1_ok_q;
    s1_data_d    = s1_data_q;
    s1_prev_d    = s1_prev_q;
    s1_x_d       = s1_x_q;
    s1_y_d       = s1_y_q;
    s2_valid_d   = 1'b0;
    s2_drop_d    = 1'b0;
    s2_sum_d     = s2_sum_q;
    s2_x_d       = s2_x_q;
    s2_y_d       = s2_y_q;
    odata_d      = odata_q;
    odval_d      = 1'b0;
    ox_d         = ox_q;
    oy_d         = oy_q;
    osof_d       = 1'b0;
    odrop_d      = 1'b0;

    if (accept) begin
      if (!odd_row) begin
        row_tag_d   = iY_Cont;
        row_valid_d = 1'b1;
      end else begin
        s1_valid_d   = 1'b1;
        s1_odd_col_d = odd_col;
        s1_ok_d      = quad_ok;
        s1_data_d    = iDATA;
        // Snapshot the left-hand sample so a following even column cannot
        // disturb a quad still in flight.
        s1_prev_d    = cur_prev_q;
        s1_x_d       = {1'b0, iX_Cont[15:1]};
        s1_y_d       = {1'b0, iY_Cont[15:1]};
        if (!odd_col) begin
          cur_prev_d  = iDATA;
          have_prev_d = 1'b1;
        end else begin
          have_prev_d = 1'b0;
        end
      end
    end

    if (s1_valid_q) begin
      if (!s1_odd_col_q) begin
        up_prev_d = line_rd;
      end else begin
        s2_valid_d = s1_ok_q;
        s2_drop_d  = !s1_ok_q;
        s2_sum_d   = {2'b00, up_prev_q} + {2'b00, line_rd}
                   + {2'b00, s1_prev_q} + {2'b00, s1_data_q};
        s2_x_d     = s1_x_q;
        s2_y_d     = s1_y_q;
      end
    end

    if (s2_valid_q) begin
      odval_d = 1'b1;
      odata_d = s2_sum_q[SW-1:2];
      ox_d    = s2_x_q;
      oy_d    = s2_y_q;
      osof_d  = (s2_x_q == 16'd0) && (s2_y_q == 16'd0);
    end
    if (s2_drop_q) begin
      odrop_d = 1'b1;
    end
  end

  // State register; reset clears tracking and every in-flight valid bit
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      row_valid_q  <= 1'b0;
      row_tag_q    <= '0;
      have_prev_q  <= 1'b0;
      cur_prev_q   <= '0;
      up_prev_q    <= '0;
      s1_valid_q   <= 1'b0;
      s1_odd_col_q <= 1'b0;
      s1_ok_q      <= 1'b0;
      s1_data_q    <= '0;
      s1_prev_q    <= '0;
      s1_x_q       <= '0;
      s1_y_q       <= '0;
      s2_valid_q   <= 1'b0;
      s2_drop_q    <= 1'b0;
      s2_sum_q     <= '0;
      s2_x_q       <= '0;
      s2_y_q       <= '0;
      odata_q      <= '0;
      odval_q      <= 1'b0;
      ox_q         <= '0;
      oy_q         <= '0;
      osof_q       <= 1'b0;
      odrop_q      <= 1'b0;
    end else begin
      row_valid_q  <= row_valid_d;
      row_tag_q    <= row_tag_d;
      have_prev_q  <= have_prev_d;
      cur_prev_q   <= cur_prev_d;
      up_prev_q    <= up_prev_d;
      s1_valid_q   <= s1_valid_d;
      s1_odd_col_q <= s1_odd_col_d;
      s1_ok_q      <= s1_ok_d;
      s1_data_q    <= s1_data_d;
      s1_prev_q    <= s1_prev_d;
      s1_x_q       <= s1_x_d;
      s1_y_q       <= s1_y_d;
      s2_valid_q   <= s2_valid_d;
      s2_drop_q    <= s2_drop_d;
      s2_sum_q     <= s2_sum_d;
      s2_x_q       <= s2_x_d;
      s2_y_q       <= s2_y_d;
      odata_q      <= odata_d;
      odval_q      <= odval_d;
      ox_q         <= ox_d;
      oy_q         <= oy_d;
      osof_q       <= osof_d;
      odrop_q      <= odrop_d;
    end
  end

  assign oDATA   = odata_q;
  assign oDVAL   = odval_q;
  assign oX_Cont = ox_q;
  assign oY_Cont = oy_q;
  assign oSOF    = osof_q;
  assign oDROP   = odrop_q;

endmodule

// File: tb/tb_bayer_gray_downsampler.sv
// Scoreboard bench for bayer_gray_downsampler: the driver pushes the
// expected result of every odd/odd beat, a negedge monitor pops and checks
// kind, timing, data, coordinates and SOF whenever an output appears.
module tb_bayer_gray_downsampler;

  logic        iCLK;
  logic        iRST;
  logic [11:0] iDATA;
  logic        iDVAL;
  logic [15:0] iX_Cont;
  logic [15:0] iY_Cont;
  logic [11:0] oDATA;
  logic        oDVAL;
  logic [15:0] oX_Cont;
  logic [15:0] oY_Cont;
  logic        oSOF;
  logic        oDROP;

  bayer_gray_downsampler #(.IN_WIDTH(1280), .DATA_W(12)) dut (
    .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iDVAL(iDVAL),
    .iX_Cont(iX_Cont), .iY_Cont(iY_Cont),
    .oDATA(oDATA), .oDVAL(oDVAL), .oX_Cont(oX_Cont), .oY_Cont(oY_Cont),
    .oSOF(oSOF), .oDROP(oDROP)
  );

  typedef struct {
    bit drop;
    int data;
    int x;
    int y;
    bit sof;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   ev[1280];
  int   od[1280];

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  always @(posedge iCLK) cyc <= cyc + 1;

  // Monitor: every output event must match the head of the queue
  always @(negedge iCLK) begin
    if (oDVAL || oDROP || oSOF) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output cyc=%0d dval=%0b drop=%0b sof=%0b data=%0d x=%0d y=%0d (none expected)",
                 cyc, oDVAL, oDROP, oSOF, oDATA, oX_Cont, oY_Cont);
      end else begin
        exp_t e;
        bit   ok;
        e  = q.pop_front();
        ok = (oDROP == e.drop) && (oDVAL == !e.drop) && (cyc == e.cyc) && (oSOF == e.sof);
        if (!e.drop)
          ok = ok && (int'(oDATA) == e.data) && (int'(oX_Cont) == e.x) && (int'(oY_Cont) == e.y);
        if (!ok) begin
          failures++;
          $display("FAIL output_match got dval=%0b drop=%0b sof=%0b data=%0d x=%0d y=%0d cyc=%0d want drop=%0b sof=%0b data=%0d x=%0d y=%0d cyc=%0d",
                   oDVAL, oDROP, oSOF, oDATA, oX_Cont, oY_Cont, cyc,
                   e.drop, e.sof, e.data, e.x, e.y, e.cyc);
        end
      end
    end
  end

  task automatic chk_zero(input string tag);
    checks++;
    if (oDATA != 0 || oDVAL || oX_Cont != 0 || oY_Cont != 0 || oSOF || oDROP) begin
      failures++;
      $display("FAIL %s got data=%0d dval=%0b x=%0d y=%0d sof=%0b drop=%0b want all zero",
               tag, oDATA, oDVAL, oX_Cont, oY_Cont, oSOF, oDROP);
    end
  endtask

  task automatic beat(input int x, input int y, input int d);
    iDVAL   = 1'b1;
    iX_Cont = 16'(x);
    iY_Cont = 16'(y);
    iDATA   = 12'(d);
    @(posedge iCLK);
    #1;
    iDVAL   = 1'b0;
  endtask

  task automatic idle(input int n);
    iDVAL = 1'b0;
    iDATA = 12'hABC;
    repeat (n) begin
      @(posedge iCLK);
      #1;
    end
  endtask

  // Called just before the odd/odd beat at column x is driven
  task automatic push(input bit drop, input int x, input int y);
    exp_t e;
    e.drop = drop;
    e.data = (ev[x-1] + ev[x] + od[x-1] + od[x]) >> 2;
    e.x    = x >> 1;
    e.y    = y >> 1;
    e.sof  = !drop && (e.x == 0) && (e.y == 0);
    e.cyc  = cyc + 3;
    q.push_back(e);
  endtask

  // Drive one row, columns 0..xlast; skip_x suppresses one expectation,
  // inject_x adds an out-of-range beat right after that column.
  task automatic drive_row(input int y, input bit drop, input bit gap,
                           input int xlast, input int skip_x, input int inject_x);
    for (int x = 0; x <= xlast; x++) begin
      if ((y % 2 == 1) && (x % 2 == 1) && (x != skip_x)) push(drop, x, y);
      beat(x, y, (y % 2 == 1) ? od[x] : ev[x]);
      if (x == inject_x) beat(1281, y, 4095);
      if (gap) idle(1);
    end
    $display("row y=%0d drop=%0b gap=%0b cols=0..%0d queued=%0d", y, drop, gap, xlast, q.size());
  endtask

  task automatic fill_flat(input int v);
    for (int x = 0; x < 1280; x++) begin
      ev[x] = v;
      od[x] = v;
    end
  endtask

  task automatic fill_pattern(input int seed);
    for (int x = 0; x < 1280; x++) begin
      ev[x] = (x * 37 + seed) % 4096;
      od[x] = (x * 53 + 7 * seed) % 4096;
    end
    // Hand-picked quads: (4095 x4)->4095, (1,2,3,5)->2, (0,0,0,3)->0
    ev[0] = 4095; ev[1] = 4095; od[0] = 4095; od[1] = 4095;
    ev[2] = 1;    ev[3] = 2;    od[2] = 3;    od[3] = 5;
    ev[4] = 0;    ev[5] = 0;    od[4] = 0;    od[5] = 3;
  endtask

  initial begin
    iRST = 1'b1; iDVAL = 1'b0; iDATA = '0; iX_Cont = '0; iY_Cont = '0;

    // Reset held 3 cycles with iDVAL toggling on odd/odd beats
    for (int i = 0; i < 3; i++) begin
      @(posedge iCLK);
      #1;
      iDVAL = (i % 2 == 0); iX_Cont = 16'd1; iY_Cont = 16'd1; iDATA = 12'hFFF;
      @(negedge iCLK);
      chk_zero("reset_hold");
    end
    @(posedge iCLK);
    #1;
    iRST = 1'b0; iDVAL = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge iCLK);
      chk_zero("reset_release");
    end
    @(posedge iCLK);
    #1;

    // Flat field contiguous, then gapped
    fill_flat(100);
    drive_row(0, 0, 0, 1279, -1, -1);
    drive_row(1, 0, 0, 1279, -1, -1);
    drive_row(0, 0, 1, 1279, -1, -1);
    drive_row(1, 0, 1, 1279, -1, -1);

    // Arithmetic corner quads plus a ramp
    fill_pattern(11);
    drive_row(2, 0, 0, 1279, -1, -1);
    drive_row(3, 0, 0, 1279, -1, -1);

    // Out-of-range beats must leave row tag and have_prev untouched
    fill_pattern(29);
    drive_row(4, 0, 0, 1279, -1, -1);
    beat(1280, 6, 4095);
    beat(1280, 4, 4095);
    drive_row(5, 0, 0, 1279, -1, 10);

    // Skipped even row: row 7 with row 4 buffered gives only drops
    drive_row(7, 1, 0, 1279, -1, -1);

    // Mid-row reset at X=600 of an odd row; X=599 is still in flight
    fill_pattern(5);
    drive_row(8, 0, 0, 1279, -1, -1);
    drive_row(9, 0, 0, 599, 599, -1);
    iRST = 1'b1;
    beat(600, 9, od[600]);
    idle(1);
    iRST = 1'b0;
    $display("mid-row reset applied at x=600 y=9");
    drive_row(9, 1, 0, 1279, -1, -1);

    // Fresh pair after reset restores valid output
    fill_pattern(77);
    drive_row(2, 0, 0, 1279, -1, -1);
    drive_row(3, 0, 0, 1279, -1, -1);

    idle(10);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL missing_outputs got %0d still pending want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
